// File: rtl/fpga_robots_game_tmap_arbiter.sv
// Round-robin arbiter sharing the tile map read/write port between game logic (A)
// and the status-area writer (B), with per-requester lock and a fixed-latency return path.
module fpga_robots_game_tmap_arbiter #(
    parameter int ADR_W   = 13,
    parameter int DAT_W   = 8,
    parameter int LOCK_TO = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_req_i,
    input  logic             a_lock_i,
    input  logic [ADR_W-1:0] a_adr_i,
    input  logic [DAT_W-1:0] a_wrt_i,
    input  logic             a_wen_i,
    output logic             a_gnt_o,
    output logic             a_rvl_o,
    output logic [DAT_W-1:0] a_red_o,
    input  logic             b_req_i,
    input  logic             b_lock_i,
    input  logic [ADR_W-1:0] b_adr_i,
    input  logic [DAT_W-1:0] b_wrt_i,
    input  logic             b_wen_i,
    output logic             b_gnt_o,
    output logic             b_rvl_o,
    output logic [DAT_W-1:0] b_red_o,
    output logic [ADR_W-1:0] tm_adr_o,
    output logic [DAT_W-1:0] tm_wrt_o,
    output logic             tm_wen_o,
    input  logic [DAT_W-1:0] tm_red_i,
    output logic [1:0]       state_o
);

    // Handshake: a requester holds req/lock/adr/wrt/wen stable until it sees gnt=1
    // at a rising edge; the access is accepted on that edge (req && gnt).
    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_LOCK_A = 2'd1,
        ST_LOCK_B = 2'd2
    } state_e;

    localparam logic [7:0] TO_LAST = 8'(LOCK_TO - 1);

    state_e           state_q;
    logic             ptr_b_q;
    logic [7:0]       timer_q;
    logic             s1_vld_q, s1_id_q, s2_vld_q, s2_id_q;
    logic [ADR_W-1:0] tm_adr_q;
    logic [DAT_W-1:0] tm_wrt_q;
    logic             tm_wen_q;
    logic             a_rvl_q, b_rvl_q;
    logic [DAT_W-1:0] a_red_q, b_red_q;

    logic             acc;
    logic             sel_lock;

    always_comb begin
        a_gnt_o = 1'b0;
        b_gnt_o = 1'b0;
        case (state_q)
            ST_LOCK_A: a_gnt_o = a_req_i;
            ST_LOCK_B: b_gnt_o = b_req_i;
            default: begin
                a_gnt_o = a_req_i && (!b_req_i || !ptr_b_q);
                b_gnt_o = b_req_i && (!a_req_i || ptr_b_q);
            end
        endcase
    end

    assign acc      = a_gnt_o || b_gnt_o;
    assign sel_lock = b_gnt_o ? b_lock_i : a_lock_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_FREE;
            ptr_b_q  <= 1'b0;
            timer_q  <= '0;
            s1_vld_q <= 1'b0;
            s1_id_q  <= 1'b0;
            s2_vld_q <= 1'b0;
            s2_id_q  <= 1'b0;
            tm_adr_q <= '0;
            tm_wrt_q <= '0;
            tm_wen_q <= 1'b0;
            a_rvl_q  <= 1'b0;
            b_rvl_q  <= 1'b0;
            a_red_q  <= '0;
            b_red_q  <= '0;
        end else begin
            // Owner tag rides alongside the access; tm_red is valid one cycle after issue.
            s1_vld_q <= acc;
            s1_id_q  <= b_gnt_o;
            s2_vld_q <= s1_vld_q;
            s2_id_q  <= s1_id_q;
            a_rvl_q  <= s2_vld_q && !s2_id_q;
            b_rvl_q  <= s2_vld_q && s2_id_q;
            if (s2_vld_q && !s2_id_q) a_red_q <= tm_red_i;
            if (s2_vld_q && s2_id_q)  b_red_q <= tm_red_i;

            if (acc) begin
                tm_adr_q <= b_gnt_o ? b_adr_i : a_adr_i;
                tm_wrt_q <= b_gnt_o ? b_wrt_i : a_wrt_i;
                tm_wen_q <= b_gnt_o ? b_wen_i : a_wen_i;
                ptr_b_q  <= !b_gnt_o;
                timer_q  <= '0;
                if (sel_lock) state_q <= b_gnt_o ? ST_LOCK_B : ST_LOCK_A;
                else          state_q <= ST_FREE;
            end else begin
                tm_wen_q <= 1'b0;
                // An owner that stops using its lock loses it; pointer already favours the other side.
                if (state_q != ST_FREE) begin
                    if (timer_q == TO_LAST) begin
                        state_q <= ST_FREE;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
            end
        end
    end

    assign tm_adr_o = tm_adr_q;
    assign tm_wrt_o = tm_wrt_q;
    assign tm_wen_o = tm_wen_q;
    assign a_rvl_o  = a_rvl_q;
    assign b_rvl_o  = b_rvl_q;
    assign a_red_o  = a_red_q;
    assign b_red_o  = b_red_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_fpga_robots_game_tmap_arbiter.sv
// Bench for the tile map arbiter: reset checks, grant vector table, directed
// corner sequences and a randomized run against a behavioural model.
module tb_fpga_robots_game_tmap_arbiter;
    localparam int ADR_W   = 13;
    localparam int DAT_W   = 8;
    localparam int LOCK_TO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic             a_req, a_lock, a_wen, b_req, b_lock, b_wen;
    logic [ADR_W-1:0] a_adr, b_adr;
    logic [DAT_W-1:0] a_wrt, b_wrt;
    logic             a_gnt, a_rvl, b_gnt, b_rvl;
    logic [DAT_W-1:0] a_red, b_red;
    logic [ADR_W-1:0] tm_adr;
    logic [DAT_W-1:0] tm_wrt, tm_red;
    logic             tm_wen;
    logic [1:0]       state_dbg;

    fpga_robots_game_tmap_arbiter #(.ADR_W(ADR_W), .DAT_W(DAT_W), .LOCK_TO(LOCK_TO)) dut (
        .clk(clk), .rst(rst),
        .a_req_i(a_req), .a_lock_i(a_lock), .a_adr_i(a_adr), .a_wrt_i(a_wrt), .a_wen_i(a_wen),
        .a_gnt_o(a_gnt), .a_rvl_o(a_rvl), .a_red_o(a_red),
        .b_req_i(b_req), .b_lock_i(b_lock), .b_adr_i(b_adr), .b_wrt_i(b_wrt), .b_wen_i(b_wen),
        .b_gnt_o(b_gnt), .b_rvl_o(b_rvl), .b_red_o(b_red),
        .tm_adr_o(tm_adr), .tm_wrt_o(tm_wrt), .tm_wen_o(tm_wen), .tm_red_i(tm_red),
        .state_o(state_dbg)
    );

    // Tile map: synchronous read, writes echo the written value.
    function automatic logic [7:0] init_val(logic [12:0] adr);
        return adr[7:0] + 8'h37;
    endfunction

    logic [7:0] mem [0:8191];
    bit         wr_flag [0:8191];
    always @(posedge clk) begin
        if (tm_wen) begin
            mem[tm_adr]     <= tm_wrt;
            wr_flag[tm_adr] <= 1'b1;
        end
        tm_red <= tm_wen ? tm_wrt : (wr_flag[tm_adr] ? mem[tm_adr] : init_val(tm_adr));
    end

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Behavioural model: lock owner (-1 none), whose turn on contention, idle count in lock.
    typedef struct {
        int         id;
        logic [7:0] data;
        int         due;
    } ret_t;

    int         own, nxt, idle;
    ret_t       ret_q[$];
    logic [7:0] exp_red [2];
    logic [12:0] e_tm_adr;
    logic [7:0] e_tm_wrt;
    logic       e_tm_wen;
    logic [7:0] shadow [0:8191];
    logic       g_a, g_b;

    task automatic model_reset();
        own = -1; nxt = 0; idle = 0;
        ret_q.delete();
        exp_red[0] = 8'h00; exp_red[1] = 8'h00;
        e_tm_adr = '0; e_tm_wrt = '0; e_tm_wen = 1'b0;
    endtask

    task automatic model_gnt(output logic ea, output logic eb);
        if (own == 0) begin ea = a_req; eb = 1'b0; end
        else if (own == 1) begin ea = 1'b0; eb = b_req; end
        else if (a_req && b_req) begin ea = (nxt == 0); eb = (nxt == 1); end
        else begin ea = a_req; eb = b_req; end
    endtask

    // Called just after the negedge with inputs applied; ends at the next negedge.
    task automatic cycle_end();
        logic ea, eb, er_a, er_b, acc_a, acc_b;
        logic [12:0] adr;
        logic [7:0] wrt, data;
        logic wen, lck;
        ret_t r;
        #1;
        model_gnt(ea, eb);
        check("a_gnt", 32'(a_gnt), 32'(ea));
        check("b_gnt", 32'(b_gnt), 32'(eb));
        g_a = a_gnt; g_b = b_gnt;
        er_a = 1'b0; er_b = 1'b0;
        if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
            r = ret_q.pop_front();
            if (r.id == 0) er_a = 1'b1; else er_b = 1'b1;
            exp_red[r.id] = r.data;
        end
        check("a_rvl", 32'(a_rvl), 32'(er_a));
        check("b_rvl", 32'(b_rvl), 32'(er_b));
        check("a_red", 32'(a_red), 32'(exp_red[0]));
        check("b_red", 32'(b_red), 32'(exp_red[1]));
        check("tm_wen", 32'(tm_wen), 32'(e_tm_wen));
        check("tm_adr", 32'(tm_adr), 32'(e_tm_adr));
        check("tm_wrt", 32'(tm_wrt), 32'(e_tm_wrt));
        acc_a = a_req && ea;
        acc_b = b_req && eb;
        adr = acc_b ? b_adr : a_adr;
        wrt = acc_b ? b_wrt : a_wrt;
        wen = acc_b ? b_wen : a_wen;
        lck = acc_b ? b_lock : a_lock;
        @(posedge clk);
        cyc++;
        if (rst) begin
            model_reset();
        end else if (acc_a || acc_b) begin
            e_tm_adr = adr; e_tm_wrt = wrt; e_tm_wen = wen;
            data = wen ? wrt : shadow[adr];
            if (wen) shadow[adr] = wrt;
            ret_q.push_back('{acc_b ? 1 : 0, data, cyc + 2});
            own  = lck ? (acc_b ? 1 : 0) : -1;
            idle = 0;
            nxt  = acc_b ? 0 : 1;
        end else begin
            e_tm_wen = 1'b0;
            if (own >= 0) begin
                if (idle == LOCK_TO - 1) begin own = -1; idle = 0; end
                else idle++;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        a_req = 1'b0; b_req = 1'b0; rst = 1'b1;
        cycle_end();
        rst = 1'b0;
    endtask

    typedef struct {
        bit ar, al, br, bl, ea, eb;
    } vec_t;
    vec_t vt [12];

    int   first_b, rvl_seen, wen_seen;
    bit   a_act, b_act;
    int   a_sleep, b_sleep;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{1, 0, 0, 0, 1, 0};
        vt[1]  = '{1, 0, 1, 0, 0, 1};
        vt[2]  = '{1, 0, 1, 0, 1, 0};
        vt[3]  = '{0, 0, 1, 0, 0, 1};
        vt[4]  = '{1, 1, 1, 0, 1, 0};
        vt[5]  = '{0, 0, 1, 0, 0, 0};
        vt[6]  = '{1, 0, 1, 0, 1, 0};
        vt[7]  = '{1, 0, 1, 0, 0, 1};
        vt[8]  = '{0, 0, 0, 0, 0, 0};
        vt[9]  = '{0, 0, 1, 1, 0, 1};
        vt[10] = '{1, 0, 1, 0, 0, 1};
        vt[11] = '{1, 0, 1, 0, 1, 0};
        for (int i = 0; i < 8192; i++) shadow[i] = init_val(13'(i));

        rst = 1'b1;
        a_req = 0; a_lock = 0; a_adr = '0; a_wrt = '0; a_wen = 0;
        b_req = 0; b_lock = 0; b_adr = '0; b_wrt = '0; b_wen = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b0;
        check("rst_tm_adr", 32'(tm_adr), 32'd0);
        check("rst_tm_wrt", 32'(tm_wrt), 32'd0);
        check("rst_tm_wen", 32'(tm_wen), 32'd0);
        check("rst_a_rvl", 32'(a_rvl), 32'd0);
        check("rst_b_rvl", 32'(b_rvl), 32'd0);
        check("rst_a_red", 32'(a_red), 32'd0);
        check("rst_b_red", 32'(b_red), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);

        // Single read of a location holding 0x5A.
        a_req = 1; a_adr = 13'h0123;
        cycle_end();
        check("rd_gnt", 32'(g_a), 32'd1);
        a_req = 0;
        check("rd_tm_adr", 32'(tm_adr), 32'h0123);
        check("rd_tm_wen", 32'(tm_wen), 32'd0);
        cycle_end();
        cycle_end();
        check("rd_a_rvl", 32'(a_rvl), 32'd1);
        check("rd_a_red", 32'(a_red), 32'h5A);
        check("rd_b_rvl", 32'(b_rvl), 32'd0);
        cycle_end();

        // Grant vector table from a fresh reset.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            a_req = vt[i].ar; a_lock = vt[i].al; b_req = vt[i].br; b_lock = vt[i].bl;
            a_adr = 13'(i); b_adr = 13'(16 + i); a_wen = 0; b_wen = 0;
            #1;
            check("vec_a_gnt", 32'(a_gnt), 32'(vt[i].ea));
            check("vec_b_gnt", 32'(b_gnt), 32'(vt[i].eb));
            cycle_end();
        end
        a_lock = 0; b_lock = 0;

        // Continuous contention alternates A,B,A,B.
        do_reset();
        a_req = 1; b_req = 1; a_adr = 13'h0200; b_adr = 13'h0300;
        for (int i = 0; i < 8; i++) begin
            cycle_end();
            check("cont_gnt", 32'({g_a, g_b}), (i % 2 == 0) ? 32'd2 : 32'd1);
            if (g_a) a_adr = a_adr + 1'b1;
            if (g_b) b_adr = b_adr + 1'b1;
        end
        a_req = 0; b_req = 0;
        repeat (3) cycle_end();

        // Locked read-modify-write by B while A keeps asking.
        do_reset();
        b_req = 1; b_lock = 1; b_adr = 13'h1780; b_wen = 0;
        cycle_end();
        check("rmw_b_rd_gnt", 32'(g_b), 32'd1);
        b_req = 0; a_req = 1; a_adr = 13'h0010; a_wen = 0;
        cycle_end();
        check("rmw_a_held", 32'(g_a), 32'd0);
        b_req = 1; b_lock = 0; b_wen = 1; b_wrt = 8'h3C;
        cycle_end();
        check("rmw_b_wr_gnt", 32'({g_a, g_b}), 32'd1);
        b_req = 0; b_wen = 0;
        cycle_end();
        check("rmw_a_after", 32'(g_a), 32'd1);
        a_req = 0;
        cycle_end();
        check("rmw_b_rvl", 32'(b_rvl), 32'd1);
        check("rmw_b_red", 32'(b_red), 32'h3C);
        repeat (2) cycle_end();

        // Abandoned lock times out after LOCK_TO cycles.
        do_reset();
        a_req = 1; a_lock = 1; b_req = 1; a_adr = 13'h0040; b_adr = 13'h0050;
        cycle_end();
        check("to_a_gnt", 32'(g_a), 32'd1);
        a_req = 0; a_lock = 0;
        first_b = -1;
        for (int i = 0; i < 40; i++) begin
            cycle_end();
            if (g_b) begin first_b = i; break; end
        end
        check("to_first_b", 32'(first_b), 32'(LOCK_TO));
        b_req = 0;
        repeat (3) cycle_end();

        // Reset right after an accepted A read.
        a_req = 1; a_adr = 13'h0077;
        cycle_end();
        a_req = 0; rst = 1;
        cycle_end();
        rst = 0;
        check("mid_tm_wen", 32'(tm_wen), 32'd0);
        check("mid_state", 32'(state_dbg), 32'd0);
        b_req = 1; b_adr = 13'h0ABC; b_wen = 0;
        rvl_seen = 0;
        cycle_end();
        check("mid_b_gnt", 32'(g_b), 32'd1);
        b_req = 0;
        for (int i = 0; i < 4; i++) begin
            cycle_end();
            if (a_rvl) rvl_seen++;
        end
        check("mid_no_a_rvl", 32'(rvl_seen), 32'd0);

        // Idle port holds the last address, no writes, no returns.
        rvl_seen = 0; wen_seen = 0;
        for (int i = 0; i < 10; i++) begin
            cycle_end();
            if (a_rvl || b_rvl) rvl_seen++;
            if (tm_wen) wen_seen++;
        end
        check("idle_tm_adr", 32'(tm_adr), 32'h0ABC);
        check("idle_rvl", 32'(rvl_seen), 32'd0);
        check("idle_wen", 32'(wen_seen), 32'd0);

        // Randomized traffic against the model.
        a_act = 0; b_act = 0; a_sleep = 0; b_sleep = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                a_act = 0; b_act = 0;
                do_reset();
            end
            if (a_sleep > 0) a_sleep--;
            else if (!a_act && ($urandom % 2 == 0)) begin
                a_act = 1; a_adr = 13'($urandom_range(0, 15)); a_wrt = 8'($urandom);
                a_wen = 1'($urandom % 2); a_lock = ($urandom_range(0, 2) == 0);
            end else if (a_act && ($urandom % 20 == 0)) a_act = 0;
            if (b_sleep > 0) b_sleep--;
            else if (!b_act && ($urandom % 2 == 0)) begin
                b_act = 1; b_adr = 13'($urandom_range(0, 15)); b_wrt = 8'($urandom);
                b_wen = 1'($urandom % 2); b_lock = ($urandom_range(0, 2) == 0);
            end else if (b_act && ($urandom % 20 == 0)) b_act = 0;
            a_req = a_act; b_req = b_act;
            cycle_end();
            if (a_req && g_a) begin
                a_act = 0;
                if ($urandom % 8 == 0) a_sleep = $urandom_range(0, 24);
            end
            if (b_req && g_b) begin
                b_act = 0;
                if ($urandom % 8 == 0) b_sleep = $urandom_range(0, 24);
            end
        end
        a_req = 0; b_req = 0;
        repeat (4) cycle_end();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fpga_robots_game_tmap_arbiter.md
Name: fpga_robots_game_tmap_arbiter

Overview:
- Shares the single external read/write port of the video block's tile map memory (tm_adr/tm_wrt/tm_wen/tm_red) between two requesters.
- Requester A is game logic; requester B is the status-area text/score writer.
- Round-robin arbitration, one access per cycle, read data routed back to the issuing requester with a fixed latency.
- A lock option lets a requester hold the port across read-modify-write sequences, e.g. updating the 4-bit work-area nibble of play-area bytes.

Parameters:
- ADR_W, 13, tile map address width
- DAT_W, 8, tile map data width
- LOCK_TO, 16, idle cycles after which an abandoned lock is forcibly released (range 2-255)

Ports:
- clk  in  1  clock, ~65MHz, rising edge
- rst  in  1  reset, synchronous, active-high
- a_req  in  1  requester A wants an access this cycle
- a_lock  in  1  keep port ownership after this access
- a_adr  in  ADR_W  A address
- a_wrt  in  DAT_W  A write data
- a_wen  in  1  A write enable
- a_gnt  out  1  combinational; A's request accepted this cycle
- a_rvl  out  1  A read data valid (registered)
- a_red  out  DAT_W  A read data (registered)
- b_req, b_lock, b_adr, b_wrt, b_wen, b_gnt, b_rvl, b_red  same as A, for requester B
- tm_adr  out  ADR_W  to tile map port (registered)
- tm_wrt  out  DAT_W  to tile map port (registered)
- tm_wen  out  1  to tile map port (registered)
- tm_red  in  DAT_W  from tile map port; valid one cycle after tm_adr/tm_wen

Behaviour:
- Reset values: tm_adr 0, tm_wrt 0, tm_wen 0, a_red/b_red 0, a_rvl/b_rvl 0. State FREE, priority pointer = A, lock timer 0.
- Handshake: a requester holds req/adr/wrt/wen/lock stable until it sees gnt=1 at a rising edge. An access is accepted on the edge where req && gnt. req may drop without a grant; nothing is issued.
- gnt is combinational from state, pointer and reqs. At most one of a_gnt/b_gnt is high in any cycle.
- States:
  - FREE: only one req → grant it. Both → grant the pointer holder.
  - LOCK_A: only A can be granted; b_gnt=0.
  - LOCK_B: mirror of LOCK_A.
- Transitions on an accepted access by X:
  - lock=1 → LOCK_X, timer cleared.
  - lock=0 → FREE.
  - Pointer always moves to the other requester.
- Lock timeout: in LOCK_X, each cycle without an accepted X access increments the timer. When the timer reaches LOCK_TO-1, the next edge forces FREE; the pointer is already at the other requester. Any accepted X access clears the timer.
- Issue: on an accepted edge, tm_adr/tm_wrt/tm_wen <= the granted requester's fields. With no accept, tm_wen <= 0 and tm_adr/tm_wrt hold their values.
- Return pipeline: a 2-stage owner tag (valid + id) follows each accepted access.
  - x_rvl is asserted exactly 2 cycles after the accepting edge, for 1 cycle.
  - x_red <= tm_red in that cycle and holds until the next x_rvl.
  - Writes also return data; the tile map echoes the written value.
- Throughput: back-to-back accepts every cycle are allowed, including alternating A/B. Return order equals issue order.
- Simultaneous events: a lock-release access by X and a pending Y request in the same cycle → X is granted this cycle, Y the next.
- Reset mid-operation:
  - All outputs return to reset values on the next edge.
  - In-flight returns are discarded: no rvl is issued for them.
  - Lock and timer are cleared.

Test Plan:
- Single read: A reads adr 0x0123 (memory holds 0x5A) → a_gnt=1 at cycle 0; tm_adr=0x0123, tm_wen=0 at cycle 1; a_rvl=1, a_red=0x5A at cycle 2; b_rvl stays 0.
- Contention: A and B both request continuously after reset → grants alternate A,B,A,B; tm_adr alternates accordingly; each rvl goes to the matching requester 2 cycles after its grant.
- Locked RMW: B reads 0x1780 with lock=1, then writes 0x3C with lock=0 while A requests throughout → a_gnt=0 until after B's write is accepted; the first A grant follows on the next cycle; b_red=0x3C for the write return.
- Lock timeout: A is granted with lock=1 and then drops req, B requesting → b_gnt first rises exactly LOCK_TO (16) cycles after A's accept edge.
- Reset mid-flight: assert rst one cycle after an A read is accepted → a_rvl never pulses; tm_wen=0, state FREE; a B request right after reset is granted immediately.
- Idle port: no requests for 10 cycles → tm_wen stays 0 and tm_adr holds its last value; no rvl pulses.
